// File: rtl/div32_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div32_pkg;

    localparam int DIV_WIDTH = 32;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div32_step.sv
// One restoring-division iteration: shift {acc,q} left, trial-subtract the
// divisor, keep the difference only when it does not go negative.
module div32_step
    import div32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] acc_shifted;
    logic [WIDTH:0] trial;
    logic           fits;

    // acc < divisor holds between steps, so the WIDTH+1 bit trial never
    // overflows and its top bit is a valid sign.
    always_comb begin
        acc_shifted = {acc, q[WIDTH-1]};
        trial       = acc_shifted - {1'b0, divisor};
        fits        = ~trial[WIDTH];
        acc_next    = fits ? trial[WIDTH-1:0] : acc_shifted[WIDTH-1:0];
        q_next      = {q[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div32_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// Define DIV32_SIGNED_EN for two's-complement (truncating) division.
module div32_seq
    import div32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ZERO_QUOT = (WIDTH <= DIV_WIDTH) ? WIDTH'(DIV_ZERO_QUOT)
                                                                  : {WIDTH{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] load_dividend;
    logic [WIDTH-1:0] load_divisor;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;
    logic             accept;
    logic             last_step;
    logic             zero_div;

    assign zero_div  = (divisor == '0);
    assign accept    = (state == IDLE) && start;
    assign last_step = (state == CALC) && (cnt == CNT_LAST);

`ifdef DIV32_SIGNED_EN
    logic neg_q;
    logic neg_r;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // The most-negative magnitude is still correct read as unsigned.
    assign load_dividend = magnitude(dividend);
    assign load_divisor  = magnitude(divisor);
    assign q_final       = neg_q ? -q_nxt : q_nxt;
    assign r_final       = neg_r ? -acc_nxt : acc_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign load_dividend = dividend;
    assign load_divisor  = divisor;
    assign q_final       = q_nxt;
    assign r_final       = acc_nxt;
`endif

    div32_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc),
        .q        (q),
        .divisor  (dvsr),
        .acc_next (acc_nxt),
        .q_next   (q_nxt)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = zero_div ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE: ;
            CALC: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Results are written on the edge that enters DONE, so they are already
    // valid while done is high and stay put until the next completion.
    // NOTE: the datapath and result registers are reset as well, because the
    // result outputs must read zero after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc         <= '0;
            q           <= '0;
            dvsr        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            acc         <= '0;
            q           <= load_dividend;
            dvsr        <= load_divisor;
            cnt         <= CNT_INIT;
            div_by_zero <= zero_div;
            if (zero_div) begin
                quotient  <= ZERO_QUOT;
                remainder <= dividend;
            end
        end else if (state == CALC) begin
            acc <= acc_nxt;
            q   <= q_nxt;
            cnt <= cnt - CNT_LAST;
            if (last_step) begin
                quotient  <= q_final;
                remainder <= r_final;
            end
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq against an arithmetic reference model.
// Build with DIV32_SIGNED_EN defined to exercise the signed variant.
module tb_div32_seq;

    localparam int W       = 32;
    localparam int LAT     = W + 1;
    localparam int TIMEOUT = 200;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    div32_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
`ifdef DIV32_SIGNED_EN
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
`else
            q = a / b;
            r = a % b;
`endif
        end
    endfunction

    function automatic logic [W-1:0] rand_divisor();
        logic [W-1:0] b;
        b = $urandom >> $urandom_range(0, 31);
        if (b == '0) b = 1;
        return b;
    endfunction

    // Issue one start pulse and wait (bounded) for done. lat counts cycles
    // from the start cycle (0) to the done cycle; busy_cnt counts busy cycles.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cnt,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (busy === 1'b1) busy_cnt++;
        q = quotient;
        r = remainder;
        z = div_by_zero;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        start    = 1'b1;
        dividend = 32'd55;
        divisor  = 32'd5;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (quotient !== '0) begin bad++; $display("FAIL reset_quot: got %h want 0", quotient); end
        total++; if (remainder !== '0) begin bad++; $display("FAIL reset_rem: got %h want 0", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset: busy got %b want 0", busy); end
    endtask

    task automatic test_unsigned_basic();
        int lat, bc;
        logic [W-1:0] q, r;
        logic z;
        do_op(32'd100, 32'd7, lat, bc, q, r, z);
        total++; if (lat !== LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        total++; if (bc !== LAT) begin bad++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, LAT); end
        total++; if (q !== 32'd14) begin bad++; $display("FAIL basic_quot: got %0d want 14", q); end
        total++; if (r !== 32'd2) begin bad++; $display("FAIL basic_rem: got %0d want 2", r); end
        total++; if (z !== 1'b0) begin bad++; $display("FAIL basic_dbz: got %b want 0", z); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_drop: got %b want 0", busy); end
        repeat (5) @(negedge clk);
        total++; if (quotient !== 32'd14) begin bad++; $display("FAIL basic_hold: got %0d want 14", quotient); end
    endtask

    task automatic test_extremes();
        logic [W-1:0] ta [3] = '{32'hFFFF_FFFF, 32'd5, 32'h1234_5678};
        logic [W-1:0] tb [3] = '{32'd1,         32'd9, 32'h1234_5678};
        logic [W-1:0] tq [3] = '{32'hFFFF_FFFF, 32'd0, 32'd1};
        logic [W-1:0] tr [3] = '{32'd0,         32'd5, 32'd0};
        int lat, bc;
        logic [W-1:0] q, r;
        logic z;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], lat, bc, q, r, z);
            total++; if (lat !== LAT) begin bad++; $display("FAIL extreme%0d_latency: got %0d want %0d", i, lat, LAT); end
            total++; if (q !== tq[i]) begin bad++; $display("FAIL extreme%0d_quot: got %h want %h", i, q, tq[i]); end
            total++; if (r !== tr[i]) begin bad++; $display("FAIL extreme%0d_rem: got %h want %h", i, r, tr[i]); end
        end
    endtask

    task automatic test_div_by_zero();
        int lat, bc;
        logic [W-1:0] q, r;
        logic z;
        do_op(32'hDEAD_BEEF, 32'd0, lat, bc, q, r, z);
        total++; if (lat !== 1) begin bad++; $display("FAIL dbz_latency: got %0d want 1", lat); end
        total++; if (q !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dbz_quot: got %h want ffffffff", q); end
        total++; if (r !== 32'hDEAD_BEEF) begin bad++; $display("FAIL dbz_rem: got %h want deadbeef", r); end
        total++; if (z !== 1'b1) begin bad++; $display("FAIL dbz_flag: got %b want 1", z); end
        repeat (4) @(negedge clk);
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag_hold: got %b want 1", div_by_zero); end
        do_op(32'd100, 32'd7, lat, bc, q, r, z);
        total++; if (z !== 1'b0) begin bad++; $display("FAIL dbz_flag_clear: got %b want 0", z); end
        total++; if (q !== 32'd14) begin bad++; $display("FAIL dbz_next_quot: got %0d want 14", q); end
    endtask

    task automatic test_handshake();
        logic [W-1:0] a, b, eq, er;
        int early_done;
        int late_activity;
        a = $urandom;
        b = rand_divisor();
        model(a, b, eq, er);
        early_done = 0;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            if (c < LAT && done === 1'b1) early_done++;
            if (c == LAT) begin
                total++; if (done !== 1'b1) begin bad++; $display("FAIL hs_done: got %b want 1", done); end
                total++; if (quotient !== eq) begin bad++; $display("FAIL hs_quot: got %h want %h", quotient, eq); end
                total++; if (remainder !== er) begin bad++; $display("FAIL hs_rem: got %h want %h", remainder, er); end
            end
            start = (c == 5 || c == 20);
            if (c == 5 || c == 20) begin
                dividend = $urandom;
                divisor  = rand_divisor();
            end
        end
        start = 1'b0;
        total++; if (early_done !== 0) begin bad++; $display("FAIL hs_early_done: got %0d want 0", early_done); end
        late_activity = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) late_activity++;
        end
        total++; if (late_activity !== 0) begin bad++; $display("FAIL hs_not_queued: got %0d want 0", late_activity); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_q [$];
        logic [W-1:0] exp_r [$];
        logic [W-1:0] a, b, eq, er;
        int n, last;
        a = $urandom;
        b = rand_divisor();
        model(a, b, eq, er);
        exp_q.push_back(eq);
        exp_r.push_back(er);
        n    = 0;
        last = -1;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        for (int c = 1; c <= 4 * (W + 2) && n < 3; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                eq = exp_q.pop_front();
                er = exp_r.pop_front();
                total++; if (quotient !== eq) begin bad++; $display("FAIL b2b%0d_quot: got %h want %h", n, quotient, eq); end
                total++; if (remainder !== er) begin bad++; $display("FAIL b2b%0d_rem: got %h want %h", n, remainder, er); end
                total++;
                if (n == 0 && c !== LAT) begin bad++; $display("FAIL b2b_first_latency: got %0d want %0d", c, LAT); end
                else if (n > 0 && c - last !== W + 2) begin bad++; $display("FAIL b2b%0d_period: got %0d want %0d", n, c - last, W + 2); end
                last = c;
                n++;
                if (n < 3) begin
                    a = $urandom;
                    b = rand_divisor();
                    model(a, b, eq, er);
                    exp_q.push_back(eq);
                    exp_r.push_back(er);
                    dividend = a;
                    divisor  = b;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        total++; if (n !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", n); end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int lat, bc, activity;
        logic [W-1:0] q, r;
        logic z;
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", done); end
        total++; if (quotient !== '0) begin bad++; $display("FAIL midrst_quot: got %h want 0", quotient); end
        total++; if (remainder !== '0) begin bad++; $display("FAIL midrst_rem: got %h want 0", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL midrst_dbz: got %b want 0", div_by_zero); end
        rst = 1'b1;
        activity = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) activity++;
        end
        total++; if (activity !== 0) begin bad++; $display("FAIL midrst_no_done: got %0d want 0", activity); end
        do_op(32'd100, 32'd7, lat, bc, q, r, z);
        total++; if (lat !== LAT) begin bad++; $display("FAIL midrst_fresh_latency: got %0d want %0d", lat, LAT); end
        total++; if (q !== 32'd14) begin bad++; $display("FAIL midrst_fresh_quot: got %0d want 14", q); end
        total++; if (r !== 32'd2) begin bad++; $display("FAIL midrst_fresh_rem: got %0d want 2", r); end
    endtask

    task automatic test_random();
        int lat, bc, exp_lat;
        logic [W-1:0] a, b, q, r, eq, er;
        logic z;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? '0 : rand_divisor();
            model(a, b, eq, er);
            exp_lat = (b == '0) ? 1 : LAT;
            do_op(a, b, lat, bc, q, r, z);
            total++; if (lat !== exp_lat) begin bad++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, exp_lat); end
            total++; if (q !== eq) begin bad++; $display("FAIL rand%0d_quot: %h/%h got %h want %h", i, a, b, q, eq); end
            total++; if (r !== er) begin bad++; $display("FAIL rand%0d_rem: %h/%h got %h want %h", i, a, b, r, er); end
            total++; if (z !== (b == '0)) begin bad++; $display("FAIL rand%0d_dbz: got %b want %b", i, z, b == '0); end
        end
    endtask

`ifdef DIV32_SIGNED_EN
    task automatic test_signed();
        logic [W-1:0] ta [3] = '{-32'sd100, 32'sd100,  32'h8000_0000};
        logic [W-1:0] tb [3] = '{32'sd7,    -32'sd7,   32'hFFFF_FFFF};
        logic [W-1:0] tq [3] = '{-32'sd14,  -32'sd14,  32'h8000_0000};
        logic [W-1:0] tr [3] = '{-32'sd2,   32'sd2,    32'd0};
        int lat, bc;
        logic [W-1:0] q, r;
        logic z;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], lat, bc, q, r, z);
            total++; if (lat !== LAT) begin bad++; $display("FAIL signed%0d_latency: got %0d want %0d", i, lat, LAT); end
            total++; if (q !== tq[i]) begin bad++; $display("FAIL signed%0d_quot: got %h want %h", i, q, tq[i]); end
            total++; if (r !== tr[i]) begin bad++; $display("FAIL signed%0d_rem: got %h want %h", i, r, tr[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned_basic();
        test_extremes();
        test_div_by_zero();
        test_handshake();
        test_back_to_back();
        test_reset_mid_op();
`ifdef DIV32_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
